// File: rtl/spu_result_tx.sv
// rtl/spu_result_tx.sv - Result FIFO plus byte-serial 4-phase strobe/ack transmitter to the host pins
module spu_result_tx #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    parameter int ACK_SYNC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    input  logic              host_ack,
    output logic [7:0]        tx_data,
    output logic              tx_strobe,
    output logic              tx_last,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int NB    = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    state_t            state, next_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [ACK_SYNC-1:0] ack_sync;
    logic              ack_s;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [BW-1:0]     byte_idx;
    logic              push, pop, advance, finish, fifo_nempty;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full slot
    assign res_ready   = (count != CW'(DEPTH));
    assign fifo_nempty = (count != '0);
    assign push        = res_valid & res_ready;
    assign ack_s       = ack_sync[ACK_SYNC-1];
    assign shreg_nxt   = shreg >> 8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= res_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear must leave the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     overflow <= 1'b0;
        else if (res_valid && !res_ready) overflow <= 1'b1;
        else if (clr_ovf)               overflow <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_sync <= '0;
        else        ack_sync <= {ack_sync[ACK_SYNC-2:0], host_ack};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (fifo_nempty && ena) next_state = SETUP;
            SETUP:   next_state = STROBE;
            STROBE:  if (ack_s) next_state = RELEASE;
            RELEASE: if (!ack_s) next_state = (byte_idx != LAST_IDX) ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && fifo_nempty && ena;
        advance   = (state == RELEASE) && !ack_s && (byte_idx != LAST_IDX);
        finish    = (state == RELEASE) && !ack_s && (byte_idx == LAST_IDX);
        tx_strobe = (state == STROBE);
        busy      = (state != IDLE) || fifo_nempty;
    end

    // tx_data only moves when leaving IDLE or RELEASE, so it is stable under the strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            byte_idx <= '0;
        end else if (pop) begin
            shreg    <= mem[rd_ptr];
            tx_data  <= mem[rd_ptr][7:0];
            tx_last  <= (NB == 1);
            byte_idx <= '0;
        end else if (advance) begin
            shreg    <= shreg_nxt;
            tx_data  <= shreg_nxt[7:0];
            tx_last  <= ((byte_idx + BW'(1)) == LAST_IDX);
            byte_idx <= byte_idx + BW'(1);
        end else if (finish) begin
            tx_last  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spu_result_tx.sv
// tb/tb_spu_result_tx.sv - Directed self-checking bench for spu_result_tx
module tb_spu_result_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        res_valid = 1'b0;
    logic [15:0] res_data = '0;
    logic        res_ready;
    logic        host_ack = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic        tx_last;
    logic        busy;
    logic        overflow;
    logic        clr_ovf = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    spu_result_tx #(.DATA_W(16), .DEPTH(4), .ACK_SYNC(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .host_ack(host_ack), .tx_data(tx_data), .tx_strobe(tx_strobe),
        .tx_last(tx_last), .busy(busy), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        res_valid = 1'b1;
        res_data  = w;
        tick(1);
        res_valid = 1'b0;
    endtask

    // Host: wait for strobe, capture byte, ack after 3 cycles, release once strobe drops
    task automatic host_byte(output logic [7:0] b, output logic l);
        int t = 0;
        while (!tx_strobe && t < 200) begin tick(1); t++; end
        if (!tx_strobe) begin
            n_checks++; n_fail++;
            $display("FAIL strobe_timeout: got 0 expected 1");
        end
        b = tx_data;
        l = tx_last;
        tick(3);
        host_ack = 1'b1;
        t = 0;
        while (tx_strobe && t < 50) begin tick(1); t++; end
        if (tx_strobe) begin
            n_checks++; n_fail++;
            $display("FAIL strobe_release_timeout: got 1 expected 0");
        end
        host_ack = 1'b0;
    endtask

    task automatic recv_word(input string name, input logic [15:0] exp);
        logic [7:0] b0, b1;
        logic       l0, l1;
        host_byte(b0, l0);
        host_byte(b1, l1);
        chk({name, "_word"}, {b1, b0}, exp);
        chk({name, "_last"}, {l0, l1}, 2'b01);
    endtask

    initial begin
        logic [7:0] b;
        logic       l;
        int         strobes;

        vecs[0] = '{16'h1234, 8'h34, 8'h12};
        vecs[1] = '{16'h00FF, 8'hFF, 8'h00};
        vecs[2] = '{16'hA55A, 8'h5A, 8'hA5};
        vecs[3] = '{16'h8001, 8'h01, 8'h80};

        #12;
        chk("rst_tx_data", tx_data, 0);
        chk("rst_strobe", tx_strobe, 0);
        chk("rst_last", tx_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ready", res_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(2);

        // Test 1: 0xBEEF with exact latencies
        res_valid = 1'b1; res_data = 16'hBEEF;
        tick(1);
        res_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_strobe_n", tx_strobe, 0);
        tick(1);
        chk("t1_b0_setup", tx_data, 8'hEF);
        chk("t1_setup_strobe", tx_strobe, 0);
        chk("t1_b0_last", tx_last, 0);
        tick(1);
        chk("t1_strobe_n2", tx_strobe, 1);
        tick(2);
        host_ack = 1'b1;
        tick(2);
        chk("t1_strobe_hold", tx_strobe, 1);
        tick(1);
        chk("t1_strobe_fall", tx_strobe, 0);
        host_ack = 1'b0;
        tick(2);
        chk("t1_data_hold", tx_data, 8'hEF);
        tick(1);
        chk("t1_b1", tx_data, 8'hBE);
        chk("t1_b1_last", tx_last, 1);
        chk("t1_b1_strobe_n", tx_strobe, 0);
        tick(1);
        chk("t1_b1_strobe", tx_strobe, 1);
        host_ack = 1'b1;
        tick(3);
        chk("t1_b1_fall", tx_strobe, 0);
        host_ack = 1'b0;
        tick(2);
        chk("t1_busy_release", busy, 1);
        tick(1);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_last", tx_last, 0);
        chk("t1_idle_data", tx_data, 8'hBE);

        // Table-driven single-word transfers
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x0, x1;
            logic       y0, y1;
            push_word(vecs[i].word);
            host_byte(x0, y0);
            host_byte(x1, y1);
            chk($sformatf("vec%0d_b0", i), x0, vecs[i].b0);
            chk($sformatf("vec%0d_b1", i), x1, vecs[i].b1);
            chk($sformatf("vec%0d_last", i), {y0, y1}, 2'b01);
            tick(4);
            chk($sformatf("vec%0d_idle", i), busy, 0);
        end

        // Tests 2/3: fill with ena low, overflow, set-beats-clear, drain in order
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            res_valid = 1'b1;
            res_data  = 16'h1100 + 16'(i * 16'h0101);
            tick(1);
            if (i == 2) chk("t2_ready_3", res_ready, 1);
            if (i == 3) chk("t2_ready_4", res_ready, 0);
        end
        res_valid = 1'b0;
        chk("t2_ovf", overflow, 1);
        res_valid = 1'b1; clr_ovf = 1'b1; res_data = 16'hDEAD;
        tick(1);
        res_valid = 1'b0;
        chk("t3_set_wins", overflow, 1);
        tick(1);
        clr_ovf = 1'b0;
        chk("t2_clr", overflow, 0);
        chk("t2_no_strobe", tx_strobe, 0);
        ena = 1'b1;
        recv_word("t2_w0", 16'h1100);
        recv_word("t2_w1", 16'h1201);
        recv_word("t2_w2", 16'h1302);
        recv_word("t2_w3", 16'h1403);
        tick(4);
        chk("t2_drained", busy, 0);

        // Test 4: ena gating
        ena = 1'b0;
        push_word(16'hC0DE);
        push_word(16'hF00D);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (tx_strobe) strobes++; end
        chk("t4_gated", strobes, 0);
        ena = 1'b1;
        host_byte(b, l);
        chk("t4_w0_b0", b, 8'hDE);
        ena = 1'b0;
        host_byte(b, l);
        chk("t4_w0_b1", b, 8'hC0);
        strobes = 0;
        for (int i = 0; i < 10; i++) begin tick(1); if (tx_strobe) strobes++; end
        chk("t4_held", strobes, 0);
        chk("t4_busy_held", busy, 1);
        ena = 1'b1;
        recv_word("t4_w1", 16'hF00D);
        tick(4);

        // Test 5: reset while strobing byte0
        push_word(16'h5AA5);
        push_word(16'h7777);
        strobes = 0;
        while (!tx_strobe && strobes < 50) begin tick(1); strobes++; end
        chk("t5_strobe_up", tx_strobe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_strobe_async", tx_strobe, 0);
        chk("t5_data_async", tx_data, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_ready_async", res_ready, 1);
        tick(2);
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin tick(1); if (tx_strobe) strobes++; end
        chk("t5_no_stale", strobes, 0);
        chk("t5_ready", res_ready, 1);
        chk("t5_busy", busy, 0);

        // Test 6: host_ack changes 1 ns before an edge
        push_word(16'h3C4B);
        strobes = 0;
        while (!tx_strobe && strobes < 50) begin tick(1); strobes++; end
        chk("t6_strobe_up", tx_strobe, 1);
        @(posedge clk);
        #9 host_ack = 1'b1;
        tick(1);
        chk("t6_e1", tx_strobe, 1);
        tick(1);
        chk("t6_e2", tx_strobe, 1);
        tick(1);
        chk("t6_e3", tx_strobe, 0);
        chk("t6_b0", tx_data, 8'h4B);
        host_ack = 1'b0;
        host_byte(b, l);
        chk("t6_b1", b, 8'h3C);
        chk("t6_b1_last", l, 1);
        tick(4);
        chk("t6_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
